// File: rtl/y86_fetch_pkg.sv
// rtl/y86_fetch_pkg.sv - shared constants and types for the y86 instruction prefetch queue
package y86_fetch_pkg;

  localparam int QBYTES_DEFAULT = 8;
  localparam int WORD_BYTES     = 4;

  typedef logic [1:0] consume_len_t;

endpackage

// File: rtl/y86_byte_ring.sv
// rtl/y86_byte_ring.sv - byte ring buffer with 4-byte append port and 4-byte head window
module y86_byte_ring
  import y86_fetch_pkg::*;
#(
  parameter int QBYTES = QBYTES_DEFAULT,
  localparam int PW = $clog2(QBYTES),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  input  logic [1:0]    wr_skip,
  input  logic          rd_valid,
  input  consume_len_t  rd_len,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic [31:0]   window
);

  logic [7:0]    mem [QBYTES];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [2:0]    wr_n;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_shift;

  // Leading lanes of an unaligned word are skipped; the rest pack in at the tail.
  assign wr_n     = 3'd4 - {1'b0, wr_skip};
  assign wr_mask  = 4'b1111 >> wr_skip;
  assign wr_shift = wr_data >> {wr_skip, 3'b000};
  assign tail     = head + count[PW-1:0];

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else begin
      if (wr_valid) count_next = count_next + CW'(wr_n);
      if (rd_valid) count_next = count_next - CW'(rd_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (clear)         head <= '0;
      else if (rd_valid) head <= head + PW'(rd_len);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid && !clear) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[tail + PW'(i)] <= wr_shift[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_win
    logic [PW-1:0] idx;
    assign idx = head + PW'(g);
    assign window[8*g +: 8] = (count > CW'(g)) ? mem[idx] : 8'h00;
  end

endmodule

// File: rtl/y86_prefetch_queue.sv
// rtl/y86_prefetch_queue.sv - y86 instruction prefetch queue: word fetch FSM feeding a byte ring
module y86_prefetch_queue
  import y86_fetch_pkg::*;
#(
  parameter int QBYTES = QBYTES_DEFAULT,
  localparam int CW = $clog2(QBYTES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_addr,
  input  logic          consume_valid,
  input  consume_len_t  consume_len,
  output logic [CW-1:0] avail,
  output logic [31:0]   instr_window,
  output logic [31:0]   instr_addr,
  output logic          protocol_err,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_addr_n;
  logic [31:0]   req_addr;
  logic [31:0]   instr_addr_q;
  logic          discard;
  logic          discard_n;
  logic          err_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          got_rsp;
  logic          append;
  logic          consume_legal;
  logic          consume_ok;
  logic          space_ok_n;

  assign got_rsp       = (state == S_WAIT) && mem_rvalid;
  assign append        = got_rsp && !discard && !redirect_valid;
  assign consume_legal = (consume_len != 2'd0) && (CW'(consume_len) <= count);
  assign consume_ok    = consume_valid && consume_legal && !redirect_valid;
  // Look at next-cycle occupancy so a fresh request can follow a response back-to-back.
  assign space_ok_n    = (CW'(QBYTES) - count_next) >= CW'(WORD_BYTES);

  always_comb begin
    fetch_addr_n = fetch_addr;
    if (redirect_valid)  fetch_addr_n = redirect_addr;
    else if (append)     fetch_addr_n = {fetch_addr[31:2], 2'b00} + 32'd4;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = space_ok_n ? S_REQ : S_IDLE;
      S_REQ:   state_n = mem_gnt ? S_WAIT : S_REQ;
      S_WAIT:  state_n = mem_rvalid ? (space_ok_n ? S_REQ : S_IDLE) : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end

  // The in-flight request survives a redirect; only its response is thrown away.
  assign discard_n = ((state == S_REQ) || (state == S_WAIT && !mem_rvalid))
                     && (redirect_valid || discard);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      fetch_addr   <= '0;
      req_addr     <= '0;
      instr_addr_q <= '0;
      discard      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_addr_n;
      discard    <= discard_n;
      if (state_n == S_REQ && state != S_REQ) req_addr <= {fetch_addr_n[31:2], 2'b00};
      if (redirect_valid)  instr_addr_q <= redirect_addr;
      else if (consume_ok) instr_addr_q <= instr_addr_q + 32'(consume_len);
      if (consume_valid && !redirect_valid && !consume_legal) err_q <= 1'b1;
    end
  end

  y86_byte_ring #(.QBYTES(QBYTES)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .wr_valid   (append),
    .wr_data    (mem_rdata),
    .wr_skip    (fetch_addr[1:0]),
    .rd_valid   (consume_ok),
    .rd_len     (consume_len),
    .count      (count),
    .count_next (count_next),
    .window     (instr_window)
  );

  assign avail        = count;
  assign instr_addr   = instr_addr_q;
  assign protocol_err = err_q;
  assign mem_req      = (state == S_REQ);
  assign mem_addr     = req_addr;

endmodule

// File: tb/tb_y86_prefetch_queue.sv
// tb/tb_y86_prefetch_queue.sv - directed self-checking bench for y86_prefetch_queue
module tb_y86_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        consume_valid;
  logic [1:0]  consume_len;
  logic [3:0]  avail;
  logic [31:0] instr_window;
  logic [31:0] instr_addr;
  logic        protocol_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  y86_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .consume_valid  (consume_valid),
    .consume_len    (consume_len),
    .avail          (avail),
    .instr_window   (instr_window),
    .instr_addr     (instr_addr),
    .protocol_err   (protocol_err),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch_word(input logic [31:0] data);
    for (int i = 0; i < 20 && !mem_req; i++) step();
    chk("req_wait", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic consume(input logic [1:0] len);
    consume_valid = 1'b1;
    consume_len   = len;
    step();
    consume_valid = 1'b0;
    consume_len   = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    consume_valid  = 1'b0;
    consume_len    = 2'd0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    step();
    step();
    chk("rst_avail",  32'(avail), 32'd0);
    chk("rst_window", instr_window, 32'h0);
    chk("rst_iaddr",  instr_addr, 32'h0);
    chk("rst_err",    32'(protocol_err), 32'd0);
    chk("rst_req",    32'(mem_req), 32'd0);
    chk("rst_maddr",  mem_addr, 32'h0);

    rst = 1'b0;
    step();
    chk("first_req",   32'(mem_req), 32'd1);
    chk("first_maddr", mem_addr, 32'h0);

    // Two back-to-back words fill the 8-byte queue
    fetch_word(32'h04030201);
    chk("w1_avail",  32'(avail), 32'd4);
    chk("w1_window", instr_window, 32'h04030201);
    chk("w1_iaddr",  instr_addr, 32'h0);
    chk("w1_req",    32'(mem_req), 32'd1);
    chk("w1_maddr",  mem_addr, 32'h4);
    fetch_word(32'h08070605);
    chk("w2_avail",  32'(avail), 32'd8);
    chk("w2_req",    32'(mem_req), 32'd0);
    chk("w2_window", instr_window, 32'h04030201);

    consume(2'd3);
    chk("c3_avail",  32'(avail), 32'd5);
    chk("c3_window", instr_window, 32'h07060504);
    chk("c3_iaddr",  instr_addr, 32'h3);
    chk("c3_req",    32'(mem_req), 32'd0);
    step();
    chk("c3_req_hold", 32'(mem_req), 32'd0);
    consume(2'd1);
    chk("c1_avail",  32'(avail), 32'd4);
    chk("c1_iaddr",  instr_addr, 32'h4);
    chk("c1_window", instr_window, 32'h08070605);
    chk("c1_req",    32'(mem_req), 32'd1);
    chk("c1_maddr",  mem_addr, 32'h8);

    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req",   32'(mem_req), 32'd1);
      chk("stall_maddr", mem_addr, 32'h8);
    end

    // Redirect while the 0x8 request is waiting for its data
    mem_gnt = 1'b1;
    step();
    mem_gnt        = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("rd_avail", 32'(avail), 32'd0);
    chk("rd_iaddr", instr_addr, 32'h102);
    chk("rd_req",   32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    step();
    mem_rvalid = 1'b0;
    chk("drop_avail", 32'(avail), 32'd0);
    chk("drop_req",   32'(mem_req), 32'd1);
    chk("drop_maddr", mem_addr, 32'h100);

    fetch_word(32'hDDCCBBAA);
    chk("ua_avail",  32'(avail), 32'd2);
    chk("ua_window", instr_window, 32'h0000DDCC);
    chk("ua_iaddr",  instr_addr, 32'h102);
    chk("ua_maddr",  mem_addr, 32'h104);

    consume(2'd3);
    chk("ill_avail",  32'(avail), 32'd2);
    chk("ill_err",    32'(protocol_err), 32'd1);
    chk("ill_window", instr_window, 32'h0000DDCC);
    chk("ill_iaddr",  instr_addr, 32'h102);
    step();
    step();
    chk("ill_sticky", 32'(protocol_err), 32'd1);

    fetch_word(32'h44332211);
    chk("w3_avail",  32'(avail), 32'd6);
    chk("w3_window", instr_window, 32'h2211DDCC);
    chk("w3_req",    32'(mem_req), 32'd0);
    consume(2'd2);
    chk("c2_avail",  32'(avail), 32'd4);
    chk("c2_window", instr_window, 32'h44332211);
    chk("c2_iaddr",  instr_addr, 32'h104);
    chk("c2_maddr",  mem_addr, 32'h108);

    // Consume and append in the same cycle
    mem_gnt = 1'b1;
    step();
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b1;
    mem_rdata     = 32'h88776655;
    consume_valid = 1'b1;
    consume_len   = 2'd2;
    step();
    mem_rvalid    = 1'b0;
    consume_valid = 1'b0;
    consume_len   = 2'd0;
    chk("sim_avail",  32'(avail), 32'd6);
    chk("sim_window", instr_window, 32'h66554433);
    chk("sim_iaddr",  instr_addr, 32'h106);

    rst = 1'b1;
    step();
    chk("rst2_avail", 32'(avail), 32'd0);
    chk("rst2_err",   32'(protocol_err), 32'd0);
    chk("rst2_iaddr", instr_addr, 32'h0);
    chk("rst2_req",   32'(mem_req), 32'd0);
    rst = 1'b0;
    step();
    chk("rst2_first", 32'(mem_req), 32'd1);
    chk("rst2_maddr", mem_addr, 32'h0);

    fetch_word(32'hA0B0C0D0);
    consume(2'd0);
    chk("z_avail",  32'(avail), 32'd4);
    chk("z_err",    32'(protocol_err), 32'd1);
    chk("z_iaddr",  instr_addr, 32'h0);
    chk("z_window", instr_window, 32'hA0B0C0D0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
